// File: rtl/alu_mux_arbiter_pkg.sv
// Shared sizes and FSM encodings for the ALU result-mux arbiter.
// Imported by the picker and the arbiter top.
package alu_mux_arbiter_pkg;
  localparam int NREQ  = 16;
  localparam int SEL_W = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
endpackage

// File: rtl/alu_mux_arbiter_rr_picker.sv
// Round-robin winner search: rotate by ptr, priority encode, add ptr back.
// Purely combinational.
module rr_picker
  import alu_mux_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [NREQ-1:0]  rot;
  logic [SEL_W-1:0] idx;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = req[SEL_W'(i) + ptr];
    end
  end

  // Scan downward so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = SEL_W'(i);
    end
  end

  assign any = |req;
  assign win = idx + ptr;

endmodule

// File: rtl/alu_mux_arbiter.sv
// Round-robin arbiter sharing the ALU 16:1 result mux among 16 requesters.
// Each grant holds sel for LAT cycles, then pulses done with the served ID.
module alu_mux_arbiter
  import alu_mux_arbiter_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [SEL_W-1:0] sel,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] done_id
);

  logic [0:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;

  logic             any;
  logic [SEL_W-1:0] win;

  rr_picker u_picker (
    .req (req),
    .ptr (ptr_q),
    .any (any),
    .win (win)
  );

  assign done = (state_q == ST_HOLD) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (any) begin
          sel_d   = win;
          gnt_d   = NREQ'(1) << win;
          cnt_d   = 4'(LAT - 1);
          state_d = ST_HOLD;
        end
      end
      (state_q == ST_HOLD): begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          gnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = (state_q == ST_HOLD);
  assign done_id = done ? sel_q : '0;

endmodule
